// File: rtl/fib_bcd.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// fib_bcd
//
// Converts the binary result of an upstream Fibonacci calculator into packed
// BCD with the sequential double-dabble (shift-and-add-3) algorithm, one bit
// per clock. A conversion starts on the rising edge of done_in and takes
// exactly INPUT_WIDTH shift steps. The result then stays on bcd_out until the
// next conversion completes.
//
// Ports
//   clk           single clock, all state changes on its rising edge
//   rst           asynchronous, active-high reset
//   done_in       upstream done level; its rising edge starts a conversion
//   result_in     upstream binary result, sampled when the conversion starts
//   overflow_in   upstream overflow flag, sampled when the conversion starts
//   bcd_out       converted value, digit 0 (ones) in bits [3:0]
//   valid         bcd_out / overflow_out hold a completed conversion
//   busy          a conversion is in progress
//   overflow_out  overflow_in captured alongside the value being converted
//   dropped       sticky: a done_in rising edge arrived while busy
// -----------------------------------------------------------------------------
module fib_bcd #(
    parameter int INPUT_WIDTH = 32,
    parameter int DIGITS      = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   done_in,
    input  logic [INPUT_WIDTH-1:0] result_in,
    input  logic                   overflow_in,
    output logic [4*DIGITS-1:0]    bcd_out,
    output logic                   valid,
    output logic                   busy,
    output logic                   overflow_out,
    output logic                   dropped
);

    // ceil(INPUT_WIDTH * log10(2)) using a fixed-point approximation of
    // log10(2) = 0.30103, accurate for any practical width.
    localparam int MIN_DIGITS = (INPUT_WIDTH * 30103 + 99999) / 100000;
    localparam int CNT_W      = $clog2(INPUT_WIDTH + 1);
    localparam int BCD_W      = 4 * DIGITS;

    generate
        if (DIGITS < MIN_DIGITS) begin : g_digits_too_small
            $error("fib_bcd: DIGITS too small for INPUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic                   done_d;
    logic                   start;
    logic                   load;
    logic                   step;
    logic                   finish;
    logic                   last_step;
    logic [CNT_W-1:0]       cnt;
    logic [INPUT_WIDTH-1:0] shreg;
    logic [BCD_W-1:0]       acc;
    logic [BCD_W-1:0]       acc_adj;
    logic [BCD_W-1:0]       acc_next;

    // A start event is the rising edge of the done level; done_d resets low so
    // a done_in already high when reset releases still counts as one.
    assign start     = done_in & ~done_d;
    assign last_step = (cnt == CNT_W'(INPUT_WIDTH - 1));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others, regardless of
    // statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (last_step) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Double-dabble step: add 3 to every digit >= 5 (digits are independent,
    // no carry between them), then shift {acc, shreg} left by one bit.
    // -------------------------------------------------------------------------
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    assign acc_next = {acc_adj[BCD_W-2:0], shreg[INPUT_WIDTH-1]};

    // -------------------------------------------------------------------------
    // Datapath and status registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_d       <= 1'b0;
            cnt          <= '0;
            shreg        <= '0;
            acc          <= '0;
            bcd_out      <= '0;
            valid        <= 1'b0;
            busy         <= 1'b0;
            overflow_out <= 1'b0;
            dropped      <= 1'b0;
        end else begin
            done_d <= done_in;

            if (load) begin
                shreg        <= result_in;
                overflow_out <= overflow_in;
                acc          <= '0;
                cnt          <= '0;
                valid        <= 1'b0;
                busy         <= 1'b1;
            end

            if (step) begin
                acc   <= acc_next;
                shreg <= shreg << 1;
                cnt   <= cnt + CNT_W'(1);
            end

            // bcd_out only changes here, so the previous result stays visible
            // for the whole duration of the next conversion.
            if (finish) begin
                bcd_out <= acc_next;
                valid   <= 1'b1;
                busy    <= 1'b0;
            end

            // A rising edge during a conversion is not queued; it is flagged.
            if (start && state == SHIFT) begin
                dropped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fib_bcd.sv
`timescale 1ns / 1ps
module tb_fib_bcd;

    localparam int W = 32;
    localparam int D = 10;

    logic           clk;
    logic           rst;
    logic           done_in;
    logic [W-1:0]   result_in;
    logic           overflow_in;
    logic [4*D-1:0] bcd_out;
    logic           valid;
    logic           busy;
    logic           overflow_out;
    logic           dropped;

    int vectors     = 0;
    int miscompares = 0;

    // Model's view of what bcd_out currently holds.
    logic [4*D-1:0] exp_bcd;

    fib_bcd #(
        .INPUT_WIDTH(W),
        .DIGITS     (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .done_in     (done_in),
        .result_in   (result_in),
        .overflow_in (overflow_in),
        .bcd_out     (bcd_out),
        .valid       (valid),
        .busy        (busy),
        .overflow_out(overflow_out),
        .dropped     (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: decimal digits by repeated division.
    function automatic logic [4*D-1:0] to_bcd(input longint unsigned v);
        logic [4*D-1:0] r;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    // Advance one clock; sample/drive 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise done_in with the given operands; the next edge is the capture edge.
    task automatic capture(input logic [W-1:0] value, input logic ovf, input string name);
        result_in   = value;
        overflow_in = ovf;
        done_in     = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s capture: busy=%b valid=%b expected busy=1 valid=0", name, busy, valid);
        end
        vectors++;
        if (overflow_out !== ovf) begin
            miscompares++;
            $display("FAIL %s ovf_capture: got %b expected %b", name, overflow_out, ovf);
        end
        vectors++;
        if (bcd_out !== exp_bcd) begin
            miscompares++;
            $display("FAIL %s hold_at_capture: got %h expected %h", name, bcd_out, exp_bcd);
        end
    endtask

    // Tick until valid (bounded); expect completion exactly W edges after capture.
    task automatic wait_done(input logic [4*D-1:0] expect_bcd, input logic ovf,
                             input int already, input string name);
        int n;
        n = already;
        while (valid !== 1'b1 && n < W + 20) begin
            tick();
            n++;
            if (valid !== 1'b1) begin
                vectors++;
                if (busy !== 1'b1 || bcd_out !== exp_bcd) begin
                    miscompares++;
                    $display("FAIL %s in_progress step %0d: busy=%b bcd=%h expected busy=1 bcd=%h",
                             name, n, busy, bcd_out, exp_bcd);
                end
            end
        end
        vectors++;
        if (n !== W) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, n, W);
        end
        vectors++;
        if (bcd_out !== expect_bcd) begin
            miscompares++;
            $display("FAIL %s bcd_out: got %h expected %h", name, bcd_out, expect_bcd);
        end
        vectors++;
        if (overflow_out !== ovf || busy !== 1'b0 || valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_flags: ovf=%b busy=%b valid=%b expected ovf=%b busy=0 valid=1",
                     name, overflow_out, busy, valid, ovf);
        end
        exp_bcd = expect_bcd;
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if (bcd_out !== '0 || valid !== 1'b0 || busy !== 1'b0 ||
            overflow_out !== 1'b0 || dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: bcd=%h valid=%b busy=%b ovf=%b dropped=%b expected all 0",
                     name, bcd_out, valid, busy, overflow_out, dropped);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        done_in     = 1'b0;
        result_in   = $urandom;
        overflow_in = 1'b1;
        exp_bcd     = '0;
        #2;
        check_all_zero("reset_async");
        repeat (3) tick();
        check_all_zero("reset_held");
        rst = 1'b0;
        tick();
        check_all_zero("reset_released_idle");
    endtask

    task automatic test_zero();
        done_in = 1'b0;
        tick();
        capture('0, 1'b0, "zero");
        wait_done(40'h0000000000, 1'b0, 0, "zero");
    endtask

    task automatic test_fib47();
        done_in = 1'b0;
        tick();
        capture(32'd2971215073, 1'b0, "fib47");
        wait_done(40'h2971215073, 1'b0, 0, "fib47");
        // done_in stays high: result must hold, no new conversion.
        for (int i = 0; i < 5; i++) begin
            result_in = $urandom;
            tick();
            vectors++;
            if (valid !== 1'b1 || busy !== 1'b0 || bcd_out !== 40'h2971215073) begin
                miscompares++;
                $display("FAIL fib47_hold: valid=%b busy=%b bcd=%h expected 1 0 2971215073",
                         valid, busy, bcd_out);
            end
        end
    endtask

    task automatic test_max_overflow();
        done_in = 1'b0;
        tick();
        capture(32'hFFFF_FFFF, 1'b1, "max_ovf");
        wait_done(40'h4294967295, 1'b1, 0, "max_ovf");
    endtask

    task automatic test_back_to_back();
        done_in = 1'b0;
        tick();
        vectors++;
        if (valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_valid_before: got %b expected 1", valid);
        end
        capture(32'd144, 1'b0, "b2b");
        wait_done(40'h0000000144, 1'b0, 0, "b2b");
        vectors++;
        if (dropped !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_dropped: got %b expected 0", dropped);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        logic         o;
        for (int i = 0; i < 20; i++) begin
            v       = $urandom;
            if (i % 4 == 0) v = v >> $urandom_range(31, 1);
            o       = 1'($urandom);
            done_in = 1'b0;
            repeat ($urandom_range(3, 1)) tick();
            capture(v, o, "random");
            wait_done(to_bcd(longint'(v)), o, 0, "random");
        end
    endtask

    task automatic test_dropped();
        logic [W-1:0] a;
        a       = $urandom;
        done_in = 1'b0;
        tick();
        capture(a, 1'b0, "dropped");       // E0
        tick();                             // E1
        tick();                             // E2
        done_in = 1'b0;
        tick();                             // E3
        tick();                             // E4 (done_d now low)
        done_in   = 1'b1;
        result_in = ~a;
        tick();                             // E5: rising edge while busy
        vectors++;
        if (dropped !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL dropped_flag: dropped=%b busy=%b expected 1 1", dropped, busy);
        end
        wait_done(to_bcd(longint'(a)), 1'b0, 5, "dropped");
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (busy !== 1'b0 || valid !== 1'b1 || dropped !== 1'b1) begin
                miscompares++;
                $display("FAIL dropped_no_second: busy=%b valid=%b dropped=%b expected 0 1 1",
                         busy, valid, dropped);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] v;
        v       = $urandom;
        done_in = 1'b0;
        tick();
        capture(v, 1'b1, "mid_reset");
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset_async");
        exp_bcd = '0;
        #2;
        rst = 1'b0;
        // done_in is still high: the next edge must capture.
        capture(v, 1'b1, "mid_reset_restart");
        wait_done(to_bcd(longint'(v)), 1'b1, 0, "mid_reset_restart");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_fib47();
        test_max_overflow();
        test_back_to_back();
        test_random();
        test_dropped();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
